// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART byte-buffer definitions: data width, default FIFO sizing and the
// per-cycle push/pop/drop decode used by the receive FIFO control logic.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int FIFO_DEPTH_LOG2 = 4;
    localparam int FIFO_IRQ_LEVEL  = 4;

    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } fifo_op_t;

    // A full FIFO still accepts a byte when the same cycle pops one; a pop on
    // an empty FIFO is ignored even if a byte is arriving in that cycle.
    function automatic fifo_op_t decode_op(
        input logic rx_done,
        input logic rd_en,
        input logic empty,
        input logic full
    );
        fifo_op_t op;
        op.pop  = rd_en && !empty;
        op.push = rx_done && (!full || op.pop);
        op.drop = rx_done && full && !op.pop;
        return op;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: one synchronous write port, one
// asynchronous read port, no reset on the array.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [DEPTH_LOG2-1:0]  wr_addr,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic [DEPTH_LOG2-1:0]  rd_addr,
    output logic [UART_DATA_W-1:0] rd_data
);

    logic [UART_DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer between the UART receiver and the register
// block; holds pointers, occupancy, sticky overrun and the interrupt decode.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
    parameter int IRQ_LEVEL  = FIFO_IRQ_LEVEL
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   rx_done,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rd_en,
    input  logic                   clr_ovr,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [DEPTH_LOG2:0]    level,
    output logic                   overrun,
    output logic                   irq
);

    localparam int                  DEPTH    = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] IRQ_LVL  = (DEPTH_LOG2+1)'(IRQ_LEVEL);
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0]  wr_ptr_q;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q;
    logic [DEPTH_LOG2:0]    level_q;
    logic                   overrun_q;
    logic [UART_DATA_W-1:0] mem_rd_data;
    fifo_op_t               op;

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign op    = decode_op(rx_done, rd_en, empty, full);

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .wr_en   (op.push),
        .wr_addr (wr_ptr_q),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (op.push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (op.pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Occupancy is tracked separately from the pointers so full and empty
    // are unambiguous when the pointers coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
        end else begin
            case ({op.push, op.pop})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop in the same cycle as clr_ovr keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (op.drop) begin
            overrun_q <= 1'b1;
        end else if (clr_ovr) begin
            overrun_q <= 1'b0;
        end
    end

    assign rd_data = empty ? '0 : mem_rd_data;
    assign level   = level_q;
    assign overrun = overrun_q;
    assign irq     = (level_q >= IRQ_LVL) || overrun_q;

endmodule
